// File: rtl/uart_pkg.sv
// Shared constants and helpers for the UART receive timing path.
// Default divisor targets a 50 MHz clock at 115200 baud, 16x oversampling.
package uart_pkg;

    localparam int DEF_DIV_INT_50M  = 27;
    localparam int DEF_DIV_FRAC_50M = 2;

    // Sample window is OVS/2-SAMP_OFS_LO .. OVS/2+SAMP_OFS_HI
    localparam int SAMP_OFS_LO = 1;
    localparam int SAMP_OFS_HI = 1;

    localparam int MIN_DIV = 2;

    function automatic int OVS_IDX_W(input int ovs);
        return $clog2(ovs);
    endfunction

endpackage

// File: rtl/uart_frac_div.sv
// Integer+fractional clock divider with shadowed divisor load.
// Emits a raw one-clock terminal-count pulse; resync restarts the period.
module uart_frac_div
    import uart_pkg::*;
#(
    parameter int DIV_W        = 16,
    parameter int FRAC_W       = 4,
    parameter int DEF_DIV_INT  = DEF_DIV_INT_50M,
    parameter int DEF_DIV_FRAC = DEF_DIV_FRAC_50M
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              div_load,
    input  logic              resync,
    output logic              tick
);

    logic [DIV_W-1:0]  cnt;
    logic [DIV_W-1:0]  act_int;
    logic [DIV_W-1:0]  sh_int;
    logic [DIV_W-1:0]  ld_int;
    logic [FRAC_W-1:0] frac_acc;
    logic [FRAC_W-1:0] act_frac;
    logic [FRAC_W-1:0] sh_frac;
    logic              ext;
    logic              pend;
    logic              apply;
    logic [DIV_W:0]    period;
    logic [DIV_W:0]    last_cnt;
    logic [FRAC_W:0]   frac_sum;

    assign ld_int = (div_int < DIV_W'(MIN_DIV)) ?
                    DIV_W'(MIN_DIV) : div_int;

    assign period   = {1'b0, act_int} + (DIV_W+1)'(ext);
    assign last_cnt = period - (DIV_W+1)'(1);
    assign frac_sum = {1'b0, frac_acc} + {1'b0, act_frac};

    // >= keeps a smaller divisor applied while idle from skipping the wrap
    assign tick  = en && !resync && ({1'b0, cnt} >= last_cnt);
    assign apply = pend && (tick || !en);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            frac_acc <= '0;
            ext      <= 1'b0;
            pend     <= 1'b0;
            act_int  <= DIV_W'(DEF_DIV_INT);
            act_frac <= FRAC_W'(DEF_DIV_FRAC);
            sh_int   <= DIV_W'(DEF_DIV_INT);
            sh_frac  <= FRAC_W'(DEF_DIV_FRAC);
        end else if (resync) begin
            cnt      <= '0;
            frac_acc <= '0;
            ext      <= 1'b0;
            pend     <= 1'b0;
            if (div_load) begin
                act_int  <= ld_int;
                act_frac <= div_frac;
                sh_int   <= ld_int;
                sh_frac  <= div_frac;
            end else if (pend) begin
                act_int  <= sh_int;
                act_frac <= sh_frac;
            end
        end else begin
            if (tick) begin
                cnt             <= '0;
                {ext, frac_acc} <= frac_sum;
            end else if (en) begin
                cnt <= cnt + DIV_W'(1);
            end
            if (apply) begin
                act_int  <= sh_int;
                act_frac <= sh_frac;
            end
            if (div_load) begin
                sh_int  <= ld_int;
                sh_frac <= div_frac;
                pend    <= 1'b1;
            end else if (apply) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_baud_tick_gen.sv
// UART Rx oversample tick generator: phase index and bit-centre strobes.
// All outputs are registered off the raw divider tick.
module uart_baud_tick_gen
    import uart_pkg::*;
#(
    parameter int DIV_W        = 16,
    parameter int FRAC_W       = 4,
    parameter int OVS          = 16,
    parameter int DEF_DIV_INT  = DEF_DIV_INT_50M,
    parameter int DEF_DIV_FRAC = DEF_DIV_FRAC_50M
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [DIV_W-1:0]          div_int,
    input  logic [FRAC_W-1:0]         div_frac,
    input  logic                      div_load,
    input  logic                      resync,
    output logic                      os_tick,
    output logic [OVS_IDX_W(OVS)-1:0] os_idx,
    output logic                      samp_tick,
    output logic                      samp_last,
    output logic                      bit_tick
);

    localparam int IW = OVS_IDX_W(OVS);

    localparam logic [IW-1:0] SAMP_LO = IW'(OVS/2 - SAMP_OFS_LO);
    localparam logic [IW-1:0] SAMP_HI = IW'(OVS/2 + SAMP_OFS_HI);

    logic          raw_tick;
    logic [IW-1:0] idx_nxt;
    logic          in_win;

    uart_frac_div #(
        .DIV_W       (DIV_W),
        .FRAC_W      (FRAC_W),
        .DEF_DIV_INT (DEF_DIV_INT),
        .DEF_DIV_FRAC(DEF_DIV_FRAC)
    ) u_div (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .div_int (div_int),
        .div_frac(div_frac),
        .div_load(div_load),
        .resync  (resync),
        .tick    (raw_tick)
    );

    // OVS is a power of two, so the natural wrap gives mod OVS
    assign idx_nxt = os_idx + IW'(1);
    assign in_win  = (idx_nxt >= SAMP_LO) && (idx_nxt <= SAMP_HI);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            os_tick   <= 1'b0;
            os_idx    <= '0;
            samp_tick <= 1'b0;
            samp_last <= 1'b0;
            bit_tick  <= 1'b0;
        end else if (resync) begin
            os_tick   <= 1'b0;
            os_idx    <= '0;
            samp_tick <= 1'b0;
            samp_last <= 1'b0;
            bit_tick  <= 1'b0;
        end else begin
            os_tick   <= raw_tick;
            samp_tick <= raw_tick && in_win;
            samp_last <= raw_tick && (idx_nxt == SAMP_HI);
            bit_tick  <= raw_tick && (idx_nxt == '0);
            if (raw_tick) begin
                os_idx <= idx_nxt;
            end
        end
    end

endmodule

// File: tb/tb_uart_baud_tick_gen.sv
// Scoreboard bench: stimulus steps a behavioural model that queues ticks;
// a monitor pops and compares whenever the DUT shows an os_tick.
module tb_uart_baud_tick_gen;

    localparam int OVS = 16;
    localparam int FU  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        div_load = 1'b0;
    logic        resync = 1'b0;
    logic [15:0] div_int = '0;
    logic [3:0]  div_frac = '0;
    logic        os_tick;
    logic [3:0]  os_idx;
    logic        samp_tick;
    logic        samp_last;
    logic        bit_tick;

    int checks = 0;
    int errors = 0;
    int ecnt = 0;
    int n_tick = 0;
    int n_bit = 0;

    typedef struct {
        int stamp;
        int idx;
        bit samp;
        bit last;
        bit bitt;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    // Model: clocks elapsed in period, fractional residue, divisors
    int m_el, m_acc, m_ext, m_ai, m_af, m_si, m_sf, m_idx;
    bit m_pend;

    uart_baud_tick_gen dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div_int  (div_int),
        .div_frac (div_frac),
        .div_load (div_load),
        .resync   (resync),
        .os_tick  (os_tick),
        .os_idx   (os_idx),
        .samp_tick(samp_tick),
        .samp_last(samp_last),
        .bit_tick (bit_tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            while (q.size() > 0 && q[0].stamp < ecnt) begin
                chk("missed_tick_cycle", ecnt, q[0].stamp);
                void'(q.pop_front());
            end
            if (os_tick) begin
                if (q.size() == 0) begin
                    chk("spurious_tick", os_tick, 0);
                end else begin
                    mon_e = q.pop_front();
                    chk("tick_cycle", ecnt, mon_e.stamp);
                    chk("os_idx", os_idx, mon_e.idx);
                    chk("samp_tick", samp_tick, mon_e.samp);
                    chk("samp_last", samp_last, mon_e.last);
                    chk("bit_tick", bit_tick, mon_e.bitt);
                    n_tick++;
                    if (bit_tick) n_bit++;
                end
            end else begin
                chk("idle_strobes",
                    {samp_tick, samp_last, bit_tick}, 0);
            end
        end
    end

    task automatic m_reset();
        m_el = 0; m_acc = 0; m_ext = 0; m_idx = 0;
        m_ai = 27; m_af = 2; m_si = 27; m_sf = 2;
        m_pend = 0;
        q.delete();
    endtask

    // Present inputs for the coming edge and predict its outcome
    task automatic step(input bit e, input bit ld, input int di,
                        input int df, input bit rs);
        int cl;
        bit bnd;
        bit apl;
        en = e; div_load = ld; resync = rs;
        div_int = di[15:0]; div_frac = df[3:0];
        cl = (di < 2) ? 2 : di;
        if (rs) begin
            m_el = 0; m_acc = 0; m_ext = 0; m_idx = 0;
            if (ld) begin
                m_ai = cl; m_af = df; m_si = cl; m_sf = df;
            end else if (m_pend) begin
                m_ai = m_si; m_af = m_sf;
            end
            m_pend = 0;
        end else begin
            bnd = e && (m_el + 1 >= m_ai + m_ext);
            apl = m_pend && (bnd || !e);
            if (bnd) begin
                m_el = 0;
                m_ext = (m_acc + m_af >= FU) ? 1 : 0;
                m_acc = (m_acc + m_af) % FU;
                m_idx = (m_idx + 1) % OVS;
                q.push_back('{ecnt + 1, m_idx,
                    (m_idx >= OVS/2-1) && (m_idx <= OVS/2+1),
                    m_idx == OVS/2+1, m_idx == 0});
            end else if (e) begin
                m_el++;
            end
            if (apl) begin
                m_ai = m_si; m_af = m_sf; m_pend = 0;
            end
            if (ld) begin
                m_si = cl; m_sf = df; m_pend = 1;
            end
        end
    endtask

    task automatic drive(input bit e, input bit ld, input int di,
                         input int df, input bit rs);
        @(negedge clk);
        #1;
        step(e, ld, di, df, rs);
    endtask

    task automatic run(input int n, input bit e);
        repeat (n) drive(e, 0, 0, 0, 0);
    endtask

    task automatic chk_zero_outs(input string tag);
        chk({tag, "_os_tick"}, os_tick, 0);
        chk({tag, "_os_idx"}, os_idx, 0);
        chk({tag, "_samp_tick"}, samp_tick, 0);
        chk({tag, "_samp_last"}, samp_last, 0);
        chk({tag, "_bit_tick"}, bit_tick, 0);
    endtask

    initial begin
        bit e, ld, rs;
        m_reset();
        repeat (3) @(negedge clk);
        #1;
        chk_zero_outs("reset");

        // Defaults 27.125: 128 ticks and 8 bits within 3472 clocks
        rst = 1'b0;
        step(1, 0, 0, 0, 1);
        n_tick = 0; n_bit = 0;
        run(3473, 1);
        chk("ticks_in_3472", n_tick, 128);
        chk("bits_in_3472", n_bit, 8);

        // 10/0 loaded with resync: 32 ticks, 2 bits in 320 clocks
        drive(1, 1, 10, 0, 1);
        n_tick = 0; n_bit = 0;
        run(321, 1);
        chk("ticks_div10", n_tick, 32);
        chk("bits_div10", n_bit, 2);

        // Load 5/0 at cnt 3 of a 27 period
        drive(1, 1, 27, 2, 1);
        run(3, 1);
        drive(1, 1, 5, 0, 0);
        run(100, 1);

        // Resync at cnt 12 with os_idx 6
        drive(1, 1, 27, 2, 1);
        run(6*27 + 12, 1);
        drive(1, 0, 0, 0, 1);
        run(60, 1);

        // en dropped for 40 clocks at cnt 9
        drive(1, 0, 0, 0, 1);
        run(9, 1);
        run(40, 0);
        run(80, 1);

        // Randomised enables, loads and resyncs with short divisors
        for (int i = 0; i < 4000; i++) begin
            e  = $urandom_range(0, 9) != 0;
            ld = $urandom_range(0, 49) == 0;
            rs = $urandom_range(0, 99) == 0;
            drive(e, ld, $urandom_range(0, 12),
                  $urandom_range(0, 15), rs);
        end

        // div_int=1 clamps to 2; async reset while a tick is showing
        drive(1, 1, 1, 0, 1);
        run(21, 1);
        chk("pre_rst_tick", os_tick, 1);
        rst = 1'b1;
        #1;
        chk_zero_outs("async_rst");
        m_reset();
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        step(1, 0, 0, 0, 0);
        run(300, 1);

        run(1, 0);
        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
